// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if
//   Bundles the two requester ports and the shared APB bus of the
//   apb_master_arbiter.
//
//   Requester handshake (req/done): a requester raises reqN with addrN,
//   wdataN, writeN and selN stable, and holds them until doneN pulses.
//   errN and rdataN are valid in the doneN cycle. The requester must drop
//   reqN in that same done cycle; it may raise it again one cycle later.
//
//   Modports:
//     master : arbiter view (drives done/err/rdata and the APB request side)
//     slave  : environment view (requesters plus APB slave)
// ---------------------------------------------------------------------------
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester port 0
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              write0;
  logic [2:0]        sel0;
  logic              done0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;
  // requester port 1
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              write1;
  logic [2:0]        sel1;
  logic              done1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;
  // APB bus
  logic [2:0]        Pselx;
  logic [ADDR_W-1:0] Paddr;
  logic              Pwrite;
  logic [DATA_W-1:0] Pwdata;
  logic              Penable;
  logic              Pready;
  logic [DATA_W-1:0] Prdata;
  logic              Pslverr;

  modport master (
    input  req0, addr0, wdata0, write0, sel0,
    input  req1, addr1, wdata1, write1, sel1,
    output done0, err0, rdata0,
    output done1, err1, rdata1,
    output Pselx, Paddr, Pwrite, Pwdata, Penable,
    input  Pready, Prdata, Pslverr
  );

  modport slave (
    output req0, addr0, wdata0, write0, sel0,
    output req1, addr1, wdata1, write1, sel1,
    input  done0, err0, rdata0,
    input  done1, err1, rdata1,
    input  Pselx, Paddr, Pwrite, Pwdata, Penable,
    output Pready, Prdata, Pslverr
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//   Two-requester round-robin arbiter and APB transfer sequencer. One
//   transfer at a time is granted, driven through APB SETUP/ACCESS, and
//   answered with a one-cycle done/err pulse plus read data to the winner.
//   Handles Pready wait states, a hung-slave timeout, Pslverr and
//   non-one-hot slave selects. All outputs are registered.
//
//   Ports:
//     Hclk     : clock, everything on the rising edge
//     Hresetn  : synchronous active-low reset
//     bus      : requester ports + APB bus (apb_master_arbiter_if.master)
//     o_state  : current FSM state (0=IDLE, 1=SETUP, 2=ACCESS) for debug
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                    Hclk,
  input  logic                    Hresetn,
  apb_master_arbiter_if.master    bus,
  output logic [1:0]              o_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2:0]        r_psel;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_penable;
  logic              r_done0, r_done1;
  logic              r_err0, r_err1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic [CW-1:0]     r_cnt;
  logic              r_last;   // last granted port
  logic              r_gnt;    // port owning the transfer in flight

  logic [2:0]        w_psel_nxt;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic              w_pwrite_nxt;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic              w_penable_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_last_nxt;
  logic              w_gnt_nxt;

  // completion event for the next cycle (shared by all termination paths)
  logic              w_fin;
  logic              w_fin_p;
  logic              w_fin_err;
  logic [DATA_W-1:0] w_fin_rdata;

  // arbitration
  logic              w_elig0, w_elig1, w_any, w_win1;
  logic [2:0]        w_sel;
  logic              w_sel_ok;
  logic [CW-1:0]     w_cnt_inc;
  logic              w_timeout;

  // A port in its done cycle is still showing req (it drops it this cycle),
  // so it is masked out to avoid a spurious second grant.
  assign w_elig0 = bus.req0 & ~r_done0;
  assign w_elig1 = bus.req1 & ~r_done1;
  assign w_any   = w_elig0 | w_elig1;
  // Port 1 wins when it is the only one, or on a tie when port 0 went last.
  assign w_win1  = w_elig1 & (~w_elig0 | ~r_last);
  assign w_sel   = w_win1 ? bus.sel1 : bus.sel0;
  assign w_sel_ok = (w_sel != 3'd0) && ((w_sel & (w_sel - 3'd1)) == 3'd0);

  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_timeout = (w_cnt_inc == CW'(TIMEOUT));

  // ---------------- state register ----------------
  always_ff @(posedge Hclk) begin
    if (!Hresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any && w_sel_ok)             w_state_nxt = S_SETUP;
      S_SETUP:                                     w_state_nxt = S_ACCESS;
      S_ACCESS: if (bus.Pready || w_timeout)       w_state_nxt = S_IDLE;
      default:                                     w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- output / datapath next values ----------------
  always_comb begin
    w_psel_nxt    = r_psel;
    w_paddr_nxt   = r_paddr;
    w_pwrite_nxt  = r_pwrite;
    w_pwdata_nxt  = r_pwdata;
    w_penable_nxt = r_penable;
    w_cnt_nxt     = r_cnt;
    w_last_nxt    = r_last;
    w_gnt_nxt     = r_gnt;
    w_fin         = 1'b0;
    w_fin_p       = r_gnt;
    w_fin_err     = 1'b0;
    w_fin_rdata   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_last_nxt = w_win1;
          w_gnt_nxt  = w_win1;
          if (w_sel_ok) begin
            w_psel_nxt    = w_sel;
            w_paddr_nxt   = w_win1 ? bus.addr1  : bus.addr0;
            w_pwdata_nxt  = w_win1 ? bus.wdata1 : bus.wdata0;
            w_pwrite_nxt  = w_win1 ? bus.write1 : bus.write0;
            w_penable_nxt = 1'b0;
            w_cnt_nxt     = '0;
          end else begin
            // bad select: answer with an error, APB stays untouched
            w_fin       = 1'b1;
            w_fin_p     = w_win1;
            w_fin_err   = 1'b1;
            w_fin_rdata = '0;
          end
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
      end
      S_ACCESS: begin
        if (bus.Pready) begin
          w_psel_nxt    = 3'd0;
          w_penable_nxt = 1'b0;
          w_fin         = 1'b1;
          w_fin_err     = bus.Pslverr;
          w_fin_rdata   = r_pwrite ? '0 : bus.Prdata;
        end else if (w_timeout) begin
          w_psel_nxt    = 3'd0;
          w_penable_nxt = 1'b0;
          w_fin         = 1'b1;
          w_fin_err     = 1'b1;
          w_fin_rdata   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_psel_nxt    = 3'd0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  // ---------------- output registers ----------------
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      r_psel    <= 3'd0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_penable <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b1;  // port 0 wins the first tie
      r_gnt     <= 1'b0;
    end else begin
      r_psel    <= w_psel_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_penable <= w_penable_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done0   <= w_fin & ~w_fin_p;
      r_done1   <= w_fin &  w_fin_p;
      r_err0    <= w_fin & ~w_fin_p & w_fin_err;
      r_err1    <= w_fin &  w_fin_p & w_fin_err;
      if (w_fin && !w_fin_p) r_rdata0 <= w_fin_rdata;
      if (w_fin &&  w_fin_p) r_rdata1 <= w_fin_rdata;
    end
  end

  assign bus.Pselx   = r_psel;
  assign bus.Paddr   = r_paddr;
  assign bus.Pwrite  = r_pwrite;
  assign bus.Pwdata  = r_pwdata;
  assign bus.Penable = r_penable;
  assign bus.done0   = r_done0;
  assign bus.done1   = r_done1;
  assign bus.err0    = r_err0;
  assign bus.err1    = r_err1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
  assign o_state     = r_state;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int W  = DW + 2;   // {port, err, rdata}

  // ---------------- clock / reset ----------------
  logic Hclk = 1'b0;
  logic Hresetn = 1'b0;
  logic [1:0] dbg_state;
  always #5 Hclk = ~Hclk;

  apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus.master),
    .o_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge Hclk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- APB slave model ----------------
  int           cfg_waits = 0;
  logic [DW-1:0] cfg_rkey = '0;
  logic         cfg_slverr = 1'b0;
  int           acc = 0;

  always @(negedge Hclk) begin
    if (bus.Penable) begin
      bus.Pready = (acc == cfg_waits);
      acc++;
    end else begin
      bus.Pready = 1'b0;
      acc = 0;
    end
    bus.Prdata  = bus.Paddr ^ cfg_rkey;
    bus.Pslverr = cfg_slverr & bus.Pready;
  end

  // ---------------- scoreboard monitor ----------------
  logic         mon_p;
  logic [W-1:0] mon_e;
  logic         gap_en = 1'b0;
  logic         gap_armed = 1'b0;
  int           last_done_cyc = 0;

  always @(negedge Hclk) begin
    if (Hresetn && (bus.done0 || bus.done1)) begin
      chk("single_done", {63'd0, bus.done0 & bus.done1}, 64'd0);
      chk("done_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_p = bus.done1;
        chk("done_port", {63'd0, mon_p}, {63'd0, mon_e[W-1]});
        chk("done_err", {63'd0, mon_p ? bus.err1 : bus.err0}, {63'd0, mon_e[W-2]});
        chk("done_rdata", {32'd0, mon_p ? bus.rdata1 : bus.rdata0}, {32'd0, mon_e[DW-1:0]});
        chk("other_err", {63'd0, mon_p ? bus.err0 : bus.err1}, 64'd0);
      end
      last_done_cyc = cyc;
      if (gap_en) gap_armed = 1'b1;
    end
    if (gap_en && gap_armed && dbg_state == 2'd1)
      chk("setup_gap", cyc - last_done_cyc, 64'd1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic w, input logic [2:0] s);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.addr0 = a; bus.wdata0 = d; bus.write0 = w; bus.sel0 = s;
    end else begin
      bus.req1 = 1'b1; bus.addr1 = a; bus.wdata1 = d; bus.write1 = w; bus.sel1 = s;
    end
  endtask

  // returns number of edges until done (first edge after the drive = 1)
  task automatic wait_done(input int p, input int budget, output int lat, output int pen);
    logic d;
    lat = 0; pen = 0; d = 1'b0;
    while (!d && lat < budget) begin
      @(negedge Hclk);
      lat++;
      if (bus.Penable) pen++;
      d = (p == 0) ? bus.done0 : bus.done1;
    end
    chk($sformatf("done%0d_seen", p), {63'd0, d}, 64'd1);
    if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Hclk);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    Hresetn = 1'b0;
    repeat (2) @(negedge Hclk);
    Hresetn = 1'b1;
  endtask

  // contention stimulus tables
  logic [AW-1:0] ct_addr[2][4];
  logic [DW-1:0] ct_data[2][4];
  logic          ct_wr[2][4];
  logic [2:0]    ct_sel[2][4];

  task automatic port_seq(input int p, input int n);
    int lat, pen;
    for (int k = 0; k < n; k++) begin
      drive_req(p, ct_addr[p][k], ct_data[p][k], ct_wr[p][k], ct_sel[p][k]);
      wait_done(p, 200, lat, pen);
      @(negedge Hclk);
    end
  endtask

  task automatic push_exp(input logic p, input logic e, input logic [DW-1:0] r);
    exp_q.push_back({p, e, r});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, pen;
    bus.req0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.write0 = 0; bus.sel0 = '0;
    bus.req1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.write1 = 0; bus.sel1 = '0;
    bus.Pready = 0; bus.Prdata = '0; bus.Pslverr = 0;

    repeat (2) @(posedge Hclk);
    @(negedge Hclk);
    chk("rst_psel", bus.Pselx, 0);
    chk("rst_penable", bus.Penable, 0);
    chk("rst_done", {bus.done0, bus.done1, bus.err0, bus.err1}, 0);
    chk("rst_rdata", {bus.rdata1, bus.rdata0}, 0);
    chk("rst_state", dbg_state, 0);
    Hresetn = 1'b1;

    // write, port 0, zero wait
    cfg_waits = 0;
    push_exp(1'b0, 1'b0, '0);
    drive_req(0, 32'h10, 32'hA5, 1'b1, 3'b001);
    @(negedge Hclk);  // after edge 1: SETUP
    chk("wr_setup_psel", bus.Pselx, 3'b001);
    chk("wr_setup_penable", bus.Penable, 0);
    chk("wr_setup_paddr", bus.Paddr, 32'h10);
    chk("wr_setup_pwdata", bus.Pwdata, 32'hA5);
    chk("wr_setup_pwrite", bus.Pwrite, 1);
    @(negedge Hclk);  // after edge 2: ACCESS
    chk("wr_access_penable", bus.Penable, 1);
    chk("wr_access_psel", bus.Pselx, 3'b001);
    @(negedge Hclk);  // after edge 3: done
    chk("wr_done0", bus.done0, 1);
    chk("wr_done_psel", bus.Pselx, 0);
    chk("wr_done_penable", bus.Penable, 0);
    bus.req0 = 1'b0;
    @(negedge Hclk);
    chk("wr_done_pulse", bus.done0, 0);
    chk("wr_paddr_hold", bus.Paddr, 32'h10);

    // read, port 1, two wait states
    cfg_waits = 2;
    cfg_rkey  = 32'hDEADBEEF ^ 32'h24;
    push_exp(1'b1, 1'b0, 32'hDEADBEEF);
    drive_req(1, 32'h24, 32'h0, 1'b0, 3'b100);
    wait_done(1, 40, lat, pen);
    chk("rd_latency", lat, 5);
    chk("rd_penable_cycles", pen, 3);
    @(negedge Hclk);
    chk("rd_rdata_hold", bus.rdata1, 32'hDEADBEEF);
    chk("rd_done_pulse", bus.done1, 0);

    // Pslverr with Pready
    cfg_waits = 1; cfg_slverr = 1'b1; cfg_rkey = 32'h1234_0000;
    push_exp(1'b0, 1'b1, 32'h30 ^ 32'h1234_0000);
    drive_req(0, 32'h30, 32'h0, 1'b0, 3'b010);
    wait_done(0, 40, lat, pen);
    chk("slverr_latency", lat, 4);
    @(negedge Hclk);
    cfg_slverr = 1'b0;
    chk("slverr_err_pulse", bus.err0, 0);

    // bad select
    push_exp(1'b0, 1'b1, '0);
    drive_req(0, 32'h50, 32'h77, 1'b1, 3'b011);
    wait_done(0, 10, lat, pen);
    chk("badsel_latency", lat, 1);
    chk("badsel_psel", bus.Pselx, 0);
    chk("badsel_state", dbg_state, 0);
    @(negedge Hclk);
    chk("badsel_psel_after", bus.Pselx, 0);

    // timeout
    cfg_waits = 1000;
    push_exp(1'b1, 1'b1, '0);
    drive_req(1, 32'h40, 32'h0, 1'b0, 3'b010);
    wait_done(1, 100, lat, pen);
    chk("to_latency", lat, 2 + TO);
    chk("to_penable_cycles", pen, TO);
    chk("to_penable_low", bus.Penable, 0);
    chk("to_psel_low", bus.Pselx, 0);
    @(negedge Hclk);

    // contention: both held, grants alternate starting with port 0
    do_reset();
    cfg_waits = $urandom_range(0, 2);
    cfg_rkey  = $urandom;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++) begin
        ct_addr[p][k] = $urandom;
        ct_data[p][k] = $urandom;
        ct_wr[p][k]   = $urandom_range(0, 1);
        ct_sel[p][k]  = 3'b001 << $urandom_range(0, 2);
        push_exp(p[0], 1'b0, ct_wr[p][k] ? '0 : (ct_addr[p][k] ^ cfg_rkey));
      end
    end
    gap_armed = 1'b0;
    gap_en    = 1'b1;
    fork
      port_seq(0, 4);
      port_seq(1, 4);
    join
    gap_en = 1'b0;
    chk("contention_drained", exp_q.size(), 0);

    // reset during ACCESS wait
    cfg_waits = 1000;
    drive_req(0, 32'h88, 32'h0, 1'b0, 3'b001);
    lat = 0;
    while (!bus.Penable && lat < 10) begin
      @(negedge Hclk);
      lat++;
    end
    chk("rst_mid_access", bus.Penable, 1);
    repeat (3) @(negedge Hclk);
    Hresetn = 1'b0;
    bus.req0 = 1'b0;
    @(negedge Hclk);
    chk("rstmid_psel", bus.Pselx, 0);
    chk("rstmid_penable", bus.Penable, 0);
    chk("rstmid_paddr", bus.Paddr, 0);
    chk("rstmid_pwrite_pwdata", {bus.Pwrite, bus.Pwdata}, 0);
    chk("rstmid_done_err", {bus.done0, bus.done1, bus.err0, bus.err1}, 0);
    chk("rstmid_rdata", {bus.rdata1, bus.rdata0}, 0);
    chk("rstmid_state", dbg_state, 0);
    cfg_waits = 0;
    cfg_rkey  = 32'hCAFE0000;
    Hresetn   = 1'b1;
    repeat (3) @(negedge Hclk);  // any stray done would hit the monitor here
    ct_addr[0][0] = 32'h100; ct_wr[0][0] = 1'b0; ct_sel[0][0] = 3'b001; ct_data[0][0] = '0;
    ct_addr[1][0] = 32'h200; ct_wr[1][0] = 1'b0; ct_sel[1][0] = 3'b100; ct_data[1][0] = '0;
    push_exp(1'b0, 1'b0, 32'h100 ^ 32'hCAFE0000);
    push_exp(1'b1, 1'b0, 32'h200 ^ 32'hCAFE0000);
    fork
      port_seq(0, 1);
      port_seq(1, 1);
    join

    repeat (3) @(negedge Hclk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-requester APB master arbiter and transfer sequencer for the AHB-to-APB bridge. It sits between two local requesters (port 0: AHB bridge write/read path; port 1: DMA/debug path) and the single shared APB bus, grants one transfer at a time by round-robin, and drives the APB SETUP/ACCESS phases. It also handles Pready wait states, a hung-slave timeout and Pslverr, and returns read data plus a one-cycle done/error pulse to the winning requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max ACCESS cycles with Pready low before forced termination (≥1)
- Hclk  input  1  single clock; all logic on rising edge
- Hresetn  input  1  reset; synchronous, active-low
- req0 / req1  input  1  transfer request; held high, with its fields stable, until the matching done pulse
- addr0 / addr1  input  ADDR_W  transfer address
- wdata0 / wdata1  input  DATA_W  write data
- write0 / write1  input  1  1 = write, 0 = read
- sel0 / sel1  input  3  one-hot slave select
- done0 / done1  output  1  one-cycle completion pulse
- err0 / err1  output  1  valid with done: Pslverr, timeout or bad select
- rdata0 / rdata1  output  DATA_W  read data, valid with done
- Pselx  output  3  APB slave select
- Paddr  output  ADDR_W  APB address
- Pwrite  output  1  APB direction
- Pwdata  output  DATA_W  APB write data
- Penable  output  1  APB enable
- Pready  input  1  slave ready
- Prdata  input  DATA_W  slave read data
- Pslverr  input  1  slave error, sampled with Pready

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- Round-robin pointer `last` holds the last granted port.
- **IDLE:**
  - A requester is eligible if its req=1 and its done is not high this cycle. A completing requester must drop req in its done cycle.
  - One eligible port: that port wins. Both eligible: the port ≠ `last` wins.
  - On a win, capture winner addr/wdata/write/sel into Paddr/Pwdata/Pwrite/Pselx, set `last`, go to SETUP with Penable=0.
- **Bad select:** if the winner's sel is not one-hot, do not start an APB transfer. Stay in IDLE, keep Pselx=0, and pulse done=1, err=1, rdata=0 for that port next cycle.
- **SETUP:** exactly one cycle. Pselx=captured sel, Penable=0. Unconditionally go to ACCESS with Penable=1.
- **ACCESS:**
  - Pready=1 at an edge: go to IDLE. Next cycle Pselx=0, Penable=0, done=1 for the granted port, rdata=Prdata (sampled at that edge; 0 on writes), err=Pslverr.
  - Pready=0: the wait counter increments. When the counter reaches TIMEOUT, go to IDLE and pulse done=1, err=1, rdata=0.
  - Wait counter width is clog2(TIMEOUT+1); it clears on entry to SETUP.
- Paddr/Pwrite/Pwdata hold their values in IDLE until the next grant.
- done/err pulse for exactly one cycle. rdata holds until that port's next done.
- The non-granted port's done/err stay 0.
- **Reset (Hresetn=0 at an edge), including mid-transfer:**
  - State=IDLE; Pselx, Paddr, Pwrite, Pwdata, Penable = 0.
  - done0/1, err0/1, rdata0/1 = 0; wait counter = 0; `last`=1, so port 0 wins the first tie.
  - No done pulse is issued for an aborted transfer.

## Timing
- Cycle numbering: req seen in IDLE at edge 0.
- Edge 1: SETUP (Psel=1, Penable=0).
- Edge 2: ACCESS (Penable=1).
- Zero wait states: Pready=1 sampled at edge 3, so done is visible after edge 3. Latency is 3 cycles.
- Each wait state adds 1 cycle.
- Back-to-back: in the done cycle, IDLE already arbitrates the other requester. Next SETUP follows at the edge after done, so there is 1 idle bus cycle between transfers.
- Pselx and the captured fields are stable from SETUP through the final ACCESS cycle. Penable is high only in ACCESS.
- Timeout: Penable stays high for exactly TIMEOUT ACCESS cycles, then drops.

## Test plan
- **Write, port 0, zero wait:** req0, addr0=0x10, wdata0=0xA5, write0=1, sel0=001, Pready=1.
  - Edge 1: Pselx=001, Penable=0, Paddr=0x10, Pwdata=0xA5, Pwrite=1.
  - Edge 2: Penable=1.
  - Edge 3: done0=1, err0=0, Pselx=0.
- **Read, port 1, two wait states:** req1, addr1=0x24, sel1=100, Pready low 2 ACCESS cycles, Prdata=0xDEADBEEF. Result: done1 pulses at edge 5, rdata1=0xDEADBEEF, err1=0.
- **Contention:** after reset, req0 and req1 both held continuously. Grants alternate 0,1,0,1. Each next SETUP follows the edge after the prior done.
- **Errors:**
  - Pslverr=1 with Pready=1: done0=1, err0=1.
  - sel0=011: no Psel activity; done0=1, err0=1 one cycle after grant.
- **Timeout:** TIMEOUT=16, Pready held 0. Penable high for 16 cycles, then done=1, err=1, rdata=0, Penable=0.
- **Reset during ACCESS:** Hresetn low for 1 cycle mid-wait. All outputs 0 next cycle, no done. With both requesting afterwards, port 0 is granted first.
